// File: rtl/clkgate_ctrl_multi.sv
// clkgate_ctrl_multi: per-channel idle-detect latch clock gate with wake handshake.
// Defining CLKGATE_STATS_EN adds GATED_CNT, a saturating 16-bit gated-cycle count per channel.
module clkgate_ctrl_multi #(
    parameter int NUM_CH   = 4,
    parameter int IDLE_W   = 4,
    parameter int WAKE_LAT = 2
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 SE,
    input  logic [NUM_CH-1:0]    E,
    input  logic [NUM_CH-1:0]    BUSY,
    input  logic [IDLE_W-1:0]    IDLE_THR,
    input  logic [NUM_CH-1:0]    WAKE_REQ,
    output logic [NUM_CH-1:0]    WAKE_ACK,
    output logic [NUM_CH-1:0]    GCK,
`ifdef CLKGATE_STATS_EN
    output logic [NUM_CH-1:0]    CH_ON,
    output logic [NUM_CH*16-1:0] GATED_CNT
`else
    output logic [NUM_CH-1:0]    CH_ON
`endif
);

    typedef enum logic [1:0] {RUN, COUNT, GATED, WAKE} state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t            state_q, state_d;
        logic [IDLE_W-1:0] idle_q, idle_d;
        logic [3:0]        wake_q, wake_d;
        logic              ack_q, ack_d, on_q, act, en, en_l;

        assign act = BUSY[i] | E[i] | WAKE_REQ[i];

        always_ff @(posedge CK) begin
            if (!RN) begin
                state_q <= RUN;
                idle_q  <= '0;
                wake_q  <= '0;
                ack_q   <= 1'b0;
                on_q    <= 1'b1;
            end else begin
                state_q <= state_d;
                idle_q  <= idle_d;
                wake_q  <= wake_d;
                ack_q   <= ack_d;
                on_q    <= state_q != GATED;
            end
        end

        always_comb begin
            state_d = state_q;
            idle_d  = idle_q;
            wake_d  = wake_q;
            ack_d   = 1'b0;
            unique case (state_q)
                RUN: begin
                    if (!act && IDLE_THR == '0) state_d = GATED;
                    else if (!act) begin
                        state_d = COUNT;
                        idle_d  = IDLE_W'(1);
                    end
                end
                COUNT: begin
                    if (act) begin
                        state_d = RUN;
                        idle_d  = '0;
                    end else if (idle_q == IDLE_THR) state_d = GATED;
                    else if (idle_q != '1) idle_d = idle_q + IDLE_W'(1);
                end
                GATED: begin
                    if (act) begin
                        state_d = WAKE;
                        wake_d  = 4'd1;
                    end
                end
                WAKE: begin
                    if (wake_q == 4'(WAKE_LAT)) begin
                        state_d = RUN;
                        ack_d   = 1'b1;
                    end else wake_d = wake_q + 4'd1;
                end
            endcase
        end

        // Reset forces the enable so GCK keeps toggling while RN is low.
        always_comb en = (state_q != GATED) | SE | !RN;

        // Low-transparent latch: enable can only change while CK is low, so no high phase is cut.
        always_latch if (!CK) en_l = en;

        assign GCK[i]      = CK & en_l;
        assign WAKE_ACK[i] = ack_q;
        assign CH_ON[i]    = on_q;

`ifdef CLKGATE_STATS_EN
        logic [15:0] cnt_q;
        always_ff @(posedge CK) begin
            if (!RN) cnt_q <= '0;
            else if (state_q == GATED && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end
        assign GATED_CNT[i*16 +: 16] = cnt_q;
`endif
    end

endmodule

// File: tb/tb_clkgate_ctrl_multi.sv
// tb_clkgate_ctrl_multi: directed scenarios for clkgate_ctrl_multi with NUM_CH=4, IDLE_W=4, WAKE_LAT=2.
module tb_clkgate_ctrl_multi;
    logic        ck = 1'b0, rn = 1'b0, se = 1'b0;
    logic [3:0]  e = '0, busy = '1, wake_req = '0, idle_thr = 4'd3;
    logic [3:0]  wake_ack, gck, ch_on;
`ifdef CLKGATE_STATS_EN
    logic [63:0] gated_cnt;
`endif
    int errors = 0, checks = 0;
    int tot_pc, tot_gl;

    clkgate_ctrl_multi #(.NUM_CH(4), .IDLE_W(4), .WAKE_LAT(2)) dut (
        .CK(ck), .RN(rn), .SE(se), .E(e), .BUSY(busy), .IDLE_THR(idle_thr),
        .WAKE_REQ(wake_req), .WAKE_ACK(wake_ack), .GCK(gck),
`ifdef CLKGATE_STATS_EN
        .CH_ON(ch_on), .GATED_CNT(gated_cnt)
`else
        .CH_ON(ch_on)
`endif
    );

    always #5 ck = ~ck;

    // Per-channel pulse counter and high-phase width monitor (full pulse is 5 time units).
    for (genvar k = 0; k < 4; k++) begin : g_mon
        int  pc = 0, gl = 0;
        time rise_t = 0;
        always @(posedge gck[k]) begin
            pc++;
            rise_t = $time;
        end
        always @(negedge gck[k]) if ($time > 0 && $time - rise_t != 5) gl++;
    end

    assign tot_pc = g_mon[0].pc + g_mon[1].pc + g_mon[2].pc + g_mon[3].pc;
    assign tot_gl = g_mon[0].gl + g_mon[1].gl + g_mon[2].gl + g_mon[3].gl;

    task automatic step(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic test_reset;
        int c0;
        c0 = g_mon[0].pc;
        step(2);
        checks++; if (ch_on !== 4'hF) begin errors++; $display("FAIL reset_ch_on: got %h exp F", ch_on); end
        checks++; if (wake_ack !== 4'h0) begin errors++; $display("FAIL reset_ack: got %h exp 0", wake_ack); end
        checks++; if (g_mon[0].pc - c0 !== 2) begin errors++; $display("FAIL reset_gck: got %0d exp 2", g_mon[0].pc - c0); end
        rn = 1'b1;
    endtask

    task automatic test_idle_gate;
        int c0, c1;
        busy = 4'b1110;
        c0 = g_mon[0].pc;
        c1 = g_mon[1].pc;
        step(4);
        checks++; if (g_mon[0].pc - c0 !== 4) begin errors++; $display("FAIL idle_pulses4: got %0d exp 4", g_mon[0].pc - c0); end
        checks++; if (ch_on[0] !== 1'b1) begin errors++; $display("FAIL idle_ch_on_pre: got %b exp 1", ch_on[0]); end
        step(1);
        checks++; if (ch_on[0] !== 1'b0) begin errors++; $display("FAIL idle_ch_on_post: got %b exp 0", ch_on[0]); end
        step(3);
        checks++; if (g_mon[0].pc - c0 !== 4) begin errors++; $display("FAIL idle_stopped: got %0d exp 4", g_mon[0].pc - c0); end
        checks++; if (g_mon[1].pc - c1 !== 8) begin errors++; $display("FAIL idle_busy_ch1: got %0d exp 8", g_mon[1].pc - c1); end
    endtask

    task automatic test_count_abort;
        int c1;
        busy = 4'b1100;
        c1 = g_mon[1].pc;
        step(2);
        busy = 4'b1110;
        step(1);
        busy = 4'b1100;
        step(3);
        checks++; if (ch_on[1] !== 1'b1) begin errors++; $display("FAIL abort_ch_on_e6: got %b exp 1", ch_on[1]); end
        step(1);
        checks++; if (ch_on[1] !== 1'b1) begin errors++; $display("FAIL abort_ch_on_e7: got %b exp 1", ch_on[1]); end
        checks++; if (g_mon[1].pc - c1 !== 7) begin errors++; $display("FAIL abort_pulses: got %0d exp 7", g_mon[1].pc - c1); end
        step(1);
        checks++; if (ch_on[1] !== 1'b0) begin errors++; $display("FAIL abort_gated: got %b exp 0", ch_on[1]); end
        checks++; if (g_mon[1].pc - c1 !== 7) begin errors++; $display("FAIL abort_stopped: got %0d exp 7", g_mon[1].pc - c1); end
    endtask

    task automatic test_wake;
        int c2, acks, ack_at;
        busy = 4'b1000;
        step(5);
        checks++; if (ch_on !== 4'b1000) begin errors++; $display("FAIL wake_pre_ch_on: got %b exp 1000", ch_on); end
        c2 = g_mon[2].pc;
        acks = 0;
        ack_at = -1;
        wake_req = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (wake_ack[2]) begin
                acks++;
                ack_at = k;
            end
            if (k == 0) begin
                checks++; if (g_mon[2].pc - c2 !== 0) begin errors++; $display("FAIL wake_no_pulse_e0: got %0d exp 0", g_mon[2].pc - c2); end
            end
            if (k == 1) begin
                checks++; if (g_mon[2].pc - c2 !== 1) begin errors++; $display("FAIL wake_first_pulse: got %0d exp 1", g_mon[2].pc - c2); end
            end
        end
        checks++; if (acks !== 1) begin errors++; $display("FAIL wake_ack_count: got %0d exp 1", acks); end
        checks++; if (ack_at !== 2) begin errors++; $display("FAIL wake_ack_time: got %0d exp 2", ack_at); end
        checks++; if (g_mon[2].pc - c2 !== 9) begin errors++; $display("FAIL wake_pulses: got %0d exp 9", g_mon[2].pc - c2); end
        wake_req = '0;
    endtask

    task automatic test_scan;
        int s;
        busy = '0;
        step(6);
        checks++; if (ch_on !== 4'h0) begin errors++; $display("FAIL scan_all_gated: got %h exp 0", ch_on); end
        s = tot_pc;
        step(2);
        checks++; if (tot_pc - s !== 0) begin errors++; $display("FAIL scan_quiet: got %0d exp 0", tot_pc - s); end
        se = 1'b1;
        #1;
        checks++; if (gck !== 4'h0) begin errors++; $display("FAIL scan_no_partial: got %h exp 0", gck); end
        step(1);
        checks++; if (tot_pc - s !== 4) begin errors++; $display("FAIL scan_first: got %0d exp 4", tot_pc - s); end
        step(3);
        checks++; if (tot_pc - s !== 16) begin errors++; $display("FAIL scan_run: got %0d exp 16", tot_pc - s); end
        checks++; if (ch_on !== 4'h0) begin errors++; $display("FAIL scan_ch_on: got %h exp 0", ch_on); end
        se = 1'b0;
        #1;
        checks++; if (gck !== 4'hF) begin errors++; $display("FAIL scan_hold_high: got %h exp F", gck); end
        step(2);
        checks++; if (tot_pc - s !== 16) begin errors++; $display("FAIL scan_regated: got %0d exp 16", tot_pc - s); end
        checks++; if (tot_gl !== 0) begin errors++; $display("FAIL scan_glitch: got %0d exp 0", tot_gl); end
    endtask

    task automatic test_thr0;
        int c3;
        busy = 4'b1000;
        step(4);
        checks++; if (ch_on[3] !== 1'b1) begin errors++; $display("FAIL thr0_awake: got %b exp 1", ch_on[3]); end
        idle_thr = 4'd0;
        busy = '0;
        c3 = g_mon[3].pc;
        step(1);
        checks++; if (g_mon[3].pc - c3 !== 1) begin errors++; $display("FAIL thr0_last_pulse: got %0d exp 1", g_mon[3].pc - c3); end
        step(1);
        checks++; if (g_mon[3].pc - c3 !== 1) begin errors++; $display("FAIL thr0_stopped: got %0d exp 1", g_mon[3].pc - c3); end
        checks++; if (ch_on[3] !== 1'b0) begin errors++; $display("FAIL thr0_ch_on: got %b exp 0", ch_on[3]); end
    endtask

    task automatic test_reset_wake;
        int acks, s;
        wake_req = 4'b0001;
        step(1);
        checks++; if (wake_ack !== 4'h0) begin errors++; $display("FAIL rstw_in_wake: got %h exp 0", wake_ack); end
        rn = 1'b0;
        wake_req = '0;
        busy = '1;
        step(1);
        checks++; if (ch_on !== 4'hF) begin errors++; $display("FAIL rstw_ch_on: got %h exp F", ch_on); end
        rn = 1'b1;
        acks = 0;
        s = tot_pc;
        for (int k = 0; k < 4; k++) begin
            step(1);
            if (wake_ack !== 4'h0) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL rstw_no_ack: got %0d exp 0", acks); end
        checks++; if (tot_pc - s !== 16) begin errors++; $display("FAIL rstw_all_run: got %0d exp 16", tot_pc - s); end
        checks++; if (ch_on !== 4'hF) begin errors++; $display("FAIL rstw_ch_on_after: got %h exp F", ch_on); end
    endtask

`ifdef CLKGATE_STATS_EN
    task automatic test_stats;
        rn = 1'b0;
        step(1);
        checks++; if (gated_cnt !== 64'h0) begin errors++; $display("FAIL stats_reset: got %h exp 0", gated_cnt); end
        rn = 1'b1;
        idle_thr = 4'd0;
        busy = 4'b1110;
        step(11);
        checks++; if (gated_cnt[15:0] !== 16'd10) begin errors++; $display("FAIL stats_count: got %0d exp 10", gated_cnt[15:0]); end
        step(70000);
        checks++; if (gated_cnt[15:0] !== 16'hFFFF) begin errors++; $display("FAIL stats_sat: got %h exp FFFF", gated_cnt[15:0]); end
        checks++; if (gated_cnt[63:16] !== 48'h0) begin errors++; $display("FAIL stats_others: got %h exp 0", gated_cnt[63:16]); end
    endtask
`endif

    initial begin
        test_reset;
        test_idle_gate;
        test_count_abort;
        test_wake;
        test_scan;
        test_thr0;
        test_reset_wake;
`ifdef CLKGATE_STATS_EN
        test_stats;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
